// File: rtl/mem_arbiter.sv
// Arbitrates one 64-bit memory port between instruction fetch and data accesses.
// Data wins ties until a waiting fetch has been passed over STARVE times.
module mem_arbiter #(
    parameter int N      = 64,
    parameter int STARVE = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         instrreq,
    input  logic [31:0]  instradr,
    input  logic         abort,
    output logic [31:0]  instr,
    output logic         hit,
    input  logic         datareq,
    input  logic [N-1:0] dataadr,
    input  logic [N-1:0] writedata,
    input  logic [1:0]   memwrite,
    output logic [N-1:0] readdata,
    output logic         dataready,
    output logic [N-1:0] madr,
    output logic [N-1:0] mwdata,
    output logic [1:0]   mwe,
    output logic         mreq,
    input  logic [N-1:0] mrdata,
    input  logic         mack
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DBUSY,
        S_IBUSY
    } state_t;

    localparam logic [3:0] STARVE_W = 4'(STARVE);

    state_t       r_state, w_state_next;
    logic [N-1:0] r_madr, w_madr_next;
    logic [N-1:0] r_mwdata, w_mwdata_next;
    logic [1:0]   r_mwe, w_mwe_next;
    logic         r_mreq, w_mreq_next;
    logic [31:0]  r_instr, w_instr_next;
    logic         r_hit, w_hit_next;
    logic [N-1:0] r_readdata, w_readdata_next;
    logic         r_dataready, w_dataready_next;
    logic [3:0]   r_starve, w_starve_next;
    logic         r_kill, w_kill_next;

    logic [N-1:0] w_dadr;
    logic [N-1:0] w_iadr;
    logic [3:0]   w_starve_inc;
    logic         w_fetch_wants;
    logic         w_unused;

    assign w_dadr        = {dataadr[N-1:3], 3'b000};
    assign w_iadr        = N'({instradr[31:3], 3'b000});
    assign w_starve_inc  = (r_starve == STARVE_W) ? r_starve : r_starve + 4'd1;
    assign w_fetch_wants = instrreq && !abort;
    assign w_unused      = ^{dataadr[2:0], instradr[1:0]};

    always_comb begin
        w_state_next     = r_state;
        w_madr_next      = r_madr;
        w_mwdata_next    = r_mwdata;
        w_mwe_next       = r_mwe;
        w_mreq_next      = r_mreq;
        w_instr_next     = r_instr;
        w_hit_next       = 1'b0;
        w_readdata_next  = r_readdata;
        w_dataready_next = 1'b0;
        w_starve_next    = r_starve;
        w_kill_next      = r_kill;

        case (r_state)
            S_IDLE: begin
                if (!instrreq) begin
                    w_starve_next = 4'd0;
                end
                if (datareq && (!instrreq || abort || (r_starve < STARVE_W))) begin
                    w_madr_next   = w_dadr;
                    w_mwdata_next = writedata;
                    w_mwe_next    = memwrite;
                    w_mreq_next   = 1'b1;
                    w_state_next  = S_DBUSY;
                    if (w_fetch_wants) begin
                        w_starve_next = w_starve_inc;
                    end
                end else if (w_fetch_wants) begin
                    w_madr_next   = w_iadr;
                    w_mwe_next    = 2'b00;
                    w_mreq_next   = 1'b1;
                    w_starve_next = 4'd0;
                    w_state_next  = S_IBUSY;
                end
            end
            S_DBUSY: begin
                if (mack) begin
                    w_readdata_next  = mrdata;
                    w_dataready_next = 1'b1;
                    w_mreq_next      = 1'b0;
                    w_mwe_next       = 2'b00;
                    w_state_next     = S_IDLE;
                end
            end
            S_IBUSY: begin
                if (abort) begin
                    w_kill_next = 1'b1;
                end
                if (mack) begin
                    // An abort landing in the ack cycle itself must also discard the word.
                    if (!r_kill && !abort) begin
                        w_instr_next = instradr[2] ? mrdata[63:32] : mrdata[31:0];
                        w_hit_next   = 1'b1;
                    end
                    w_mreq_next  = 1'b0;
                    w_kill_next  = 1'b0;
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_madr      <= '0;
            r_mwdata    <= '0;
            r_mwe       <= 2'b00;
            r_mreq      <= 1'b0;
            r_instr     <= '0;
            r_hit       <= 1'b0;
            r_readdata  <= '0;
            r_dataready <= 1'b0;
            r_starve    <= 4'd0;
            r_kill      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_madr      <= w_madr_next;
            r_mwdata    <= w_mwdata_next;
            r_mwe       <= w_mwe_next;
            r_mreq      <= w_mreq_next;
            r_instr     <= w_instr_next;
            r_hit       <= w_hit_next;
            r_readdata  <= w_readdata_next;
            r_dataready <= w_dataready_next;
            r_starve    <= w_starve_next;
            r_kill      <= w_kill_next;
        end
    end

    assign madr      = r_madr;
    assign mwdata    = r_mwdata;
    assign mwe       = r_mwe;
    assign mreq      = r_mreq;
    assign instr     = r_instr;
    assign hit       = r_hit;
    assign readdata  = r_readdata;
    assign dataready = r_dataready;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a delayed-ack memory model plus scenario tasks and
// a randomized run checked against a transaction-level shadow memory.
module tb_mem_arbiter;
    localparam int N      = 64;
    localparam int STARVE = 4;

    logic          clk = 1'b0;
    logic          reset, instrreq, abort, datareq, mack, hit, dataready, mreq;
    logic [31:0]   instradr, instr;
    logic [N-1:0]  dataadr, writedata, readdata, madr, mwdata, mrdata;
    logic [1:0]    memwrite, mwe;

    int            pass_cnt = 0;
    int            total_cnt = 0;
    logic [63:0]   mem     [32];
    logic [63:0]   ref_mem [32];
    int            resp_delay = 0;
    logic          resp_en = 1'b1;
    logic          force_mack = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter #(.N(N), .STARVE(STARVE)) dut (
        .clk(clk), .reset(reset),
        .instrreq(instrreq), .instradr(instradr), .abort(abort), .instr(instr), .hit(hit),
        .datareq(datareq), .dataadr(dataadr), .writedata(writedata), .memwrite(memwrite),
        .readdata(readdata), .dataready(dataready),
        .madr(madr), .mwdata(mwdata), .mwe(mwe), .mreq(mreq), .mrdata(mrdata), .mack(mack)
    );

    // Memory model: acks after resp_delay cycles of mreq, returns the old word, then writes lanes.
    initial begin
        int cnt;
        cnt    = 0;
        mack   = 1'b0;
        mrdata = '0;
        forever begin
            @(posedge clk);
            #2;
            if (!resp_en) begin
                mack = force_mack;
                cnt  = 0;
            end else if (mack) begin
                mack = 1'b0;
                cnt  = 0;
            end else if (mreq) begin
                if (cnt >= resp_delay) begin
                    mack   = 1'b1;
                    mrdata = mem[madr[7:3]];
                    if (mwe[0]) mem[madr[7:3]][31:0]  = mwdata[31:0];
                    if (mwe[1]) mem[madr[7:3]][63:32] = mwdata[63:32];
                end else begin
                    cnt++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // which: 0 = mreq, 1 = hit, 2 = dataready
    task automatic wait_for(input int which, output bit ok, output int cycles);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            cycles = i;
            if ((which == 0 && mreq) || (which == 1 && hit) || (which == 2 && dataready)) begin
                ok = 1'b1;
                return;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; instrreq = 0; abort = 0; datareq = 0;
        instradr = '0; dataadr = '0; writedata = '0; memwrite = 2'b00;
        repeat (3) tick();
        total_cnt++; if ({mreq, mwe, hit, dataready} !== 5'b0) $display("FAIL reset_ctrl got %b want 00000", {mreq, mwe, hit, dataready}); else pass_cnt++;
        total_cnt++; if (madr !== '0) $display("FAIL reset_madr got %h want 0", madr); else pass_cnt++;
        total_cnt++; if (mwdata !== '0) $display("FAIL reset_mwdata got %h want 0", mwdata); else pass_cnt++;
        total_cnt++; if ({instr, readdata} !== '0) $display("FAIL reset_results got %h/%h want 0", instr, readdata); else pass_cnt++;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        bit ok; int cyc; int pulses;
        resp_en = 1'b0;
        datareq = 1'b1; dataadr = 64'h40; memwrite = 2'b00;
        tick();
        wait_for(0, ok, cyc);
        total_cnt++; if (ok !== 1'b1) $display("FAIL rstmid_grant got no mreq want mreq"); else pass_cnt++;
        reset = 1'b1; datareq = 1'b0;
        tick();
        reset = 1'b0;
        total_cnt++; if ({mreq, dataready} !== 2'b00) $display("FAIL rstmid_idle got mreq/dready %b want 00", {mreq, dataready}); else pass_cnt++;
        force_mack = 1'b1;
        tick();
        force_mack = 1'b0;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (dataready || hit || mreq) pulses++;
        end
        total_cnt++; if (pulses !== 0) $display("FAIL rstmid_stale_ack got %0d activity cycles want 0", pulses); else pass_cnt++;
        resp_en = 1'b1;
        tick();
        $display("txn reset_mid done");
    endtask

    task automatic test_fetch();
        bit ok; int cyc;
        mem[0] = 64'h1111_2222_3333_4444; ref_mem[0] = 64'h1111_2222_3333_4444;
        resp_delay = 2;
        instrreq = 1'b1; instradr = 32'h0000_0004;
        tick();
        total_cnt++; if (mreq !== 1'b1) $display("FAIL fetch_latency got mreq %b want 1", mreq); else pass_cnt++;
        total_cnt++; if ({madr, mwe} !== {64'h0, 2'b00}) $display("FAIL fetch_madr got %h/%b want 0/00", madr, mwe); else pass_cnt++;
        wait_for(1, ok, cyc);
        instrreq = 1'b0;
        total_cnt++; if (!ok || cyc !== 3) $display("FAIL fetch_hit_time got ok=%0d cyc=%0d want ok=1 cyc=3", ok, cyc); else pass_cnt++;
        total_cnt++; if (instr !== 32'h1111_2222) $display("FAIL fetch_instr got %h want 11112222", instr); else pass_cnt++;
        tick();
        total_cnt++; if (hit !== 1'b0) $display("FAIL fetch_hit_pulse got hit %b want 0", hit); else pass_cnt++;
        $display("txn fetch adr=00000004 instr=%h", instr);
    endtask

    task automatic test_load_store();
        bit ok; int cyc; int bad; logic [63:0] old;
        mem[8] = 64'h0123_4567_89AB_CDEF; ref_mem[8] = 64'h0123_4567_89AB_CDEF;
        resp_delay = 1;
        datareq = 1'b1; dataadr = 64'h40; memwrite = 2'b00; writedata = '0;
        tick();
        total_cnt++; if ({mreq, madr, mwe} !== {1'b1, 64'h40, 2'b00}) $display("FAIL load_grant got %b/%h/%b want 1/40/00", mreq, madr, mwe); else pass_cnt++;
        wait_for(2, ok, cyc);
        datareq = 1'b0;
        total_cnt++; if (!ok || readdata !== ref_mem[8]) $display("FAIL load_data got %h want %h", readdata, ref_mem[8]); else pass_cnt++;
        tick();
        total_cnt++; if (dataready !== 1'b0) $display("FAIL load_pulse got dataready %b want 0", dataready); else pass_cnt++;
        $display("txn load adr=40 data=%h", readdata);

        old = ref_mem[8];
        resp_delay = 3;
        datareq = 1'b1; memwrite = 2'b01; writedata = 64'hAAAA_BBBB_CCCC_DDDD;
        tick();
        bad = 0; ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (dataready) ok = 1'b1;
            else begin
                if ({mreq, mwe, mwdata} !== {1'b1, 2'b01, 64'hAAAA_BBBB_CCCC_DDDD}) bad++;
                tick();
            end
        end
        datareq = 1'b0;
        total_cnt++; if (!ok || bad !== 0) $display("FAIL store_hold got ok=%0d bad=%0d want ok=1 bad=0", ok, bad); else pass_cnt++;
        total_cnt++; if (readdata !== old) $display("FAIL store_readdata got %h want %h", readdata, old); else pass_cnt++;
        ref_mem[8][31:0] = 32'hCCCC_DDDD;
        tick();
        $display("txn store adr=40 we=01 data=aaaabbbbccccdddd");
    endtask

    task automatic test_starve();
        int grants; int mcnt; bit prev; bit exp_f; bit got_f; bit done;
        resp_delay = 0;
        datareq = 1'b1; dataadr = 64'h80; memwrite = 2'b00;
        instrreq = 1'b1; instradr = 32'h100;
        grants = 0; mcnt = 0; prev = 1'b0; done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            tick();
            if (mreq && !prev) begin
                exp_f = (mcnt == STARVE);
                got_f = (madr == 64'h100);
                total_cnt++; if (got_f !== exp_f) $display("FAIL starve_grant%0d got fetch=%0d want fetch=%0d", grants, got_f, exp_f); else pass_cnt++;
                mcnt = exp_f ? 0 : mcnt + 1;
                grants++;
                if (grants == 10) datareq = 1'b0;
            end
            if (hit && grants >= 10) begin
                instrreq = 1'b0;
                done = 1'b1;
            end
            prev = mreq;
        end
        total_cnt++; if (!done) $display("FAIL starve_timeout got %0d grants want 10 then hit", grants); else pass_cnt++;
        tick();
        $display("txn starve grants=%0d", grants);
    endtask

    task automatic test_abort();
        bit ok; int cyc; int hits;
        mem[1] = 64'hDEAD_BEEF_F00D_CAFE; ref_mem[1] = 64'hDEAD_BEEF_F00D_CAFE;
        resp_delay = 4;
        instrreq = 1'b1; instradr = 32'h08;
        tick();
        abort = 1'b1; instrreq = 1'b0;
        tick();
        abort = 1'b0;
        hits = 0;
        for (int i = 0; i < 12; i++) begin
            if (hit) hits++;
            tick();
        end
        total_cnt++; if (hits !== 0) $display("FAIL abort_hit got %0d hits want 0", hits); else pass_cnt++;
        total_cnt++; if (mreq !== 1'b0) $display("FAIL abort_release got mreq %b want 0", mreq); else pass_cnt++;
        resp_delay = 1;
        instrreq = 1'b1; instradr = 32'h0C;
        tick();
        wait_for(1, ok, cyc);
        instrreq = 1'b0;
        total_cnt++; if (!ok || instr !== ref_mem[1][63:32]) $display("FAIL abort_refetch got ok=%0d %h want %h", ok, instr, ref_mem[1][63:32]); else pass_cnt++;
        tick();
        $display("txn abort then fetch instr=%h", instr);
    endtask

    task automatic test_hold();
        int pulses; int stable; int bad; logic [63:0] wd;
        wd = {$urandom, $urandom};
        resp_delay = 10;
        datareq = 1'b1; dataadr = 64'h18; memwrite = 2'b10; writedata = wd;
        tick();
        pulses = 0; stable = 0; bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (dataready) begin
                pulses++;
                datareq = 1'b0;
            end else if (pulses == 0) begin
                if ({mreq, madr, mwe, mwdata} !== {1'b1, 64'h18, 2'b10, wd}) bad++;
                stable++;
            end
            tick();
        end
        total_cnt++; if (bad !== 0) $display("FAIL hold_stable got %0d unstable cycles want 0", bad); else pass_cnt++;
        total_cnt++; if (stable !== 11) $display("FAIL hold_length got %0d want 11", stable); else pass_cnt++;
        total_cnt++; if (pulses !== 1) $display("FAIL hold_pulses got %0d want 1", pulses); else pass_cnt++;
        ref_mem[3][63:32] = wd[63:32];
        $display("txn hold store adr=18 we=10 pulses=%0d", pulses);
    endtask

    task automatic test_random();
        bit ok; int cyc; int kind; int idx; int lane; logic [1:0] we; logic [63:0] wd; logic [31:0] exp_i;
        for (int t = 0; t < 40; t++) begin
            kind = int'($urandom_range(0, 2));
            idx  = int'($urandom_range(0, 31));
            resp_delay = int'($urandom_range(0, 5));
            if (kind == 2) begin
                lane = int'($urandom_range(0, 1));
                instradr = 32'(idx * 8 + lane * 4);
                instrreq = 1'b1;
                tick();
                total_cnt++; if ({mreq, madr, mwe} !== {1'b1, 64'(idx * 8), 2'b00}) $display("FAIL rnd%0d_fgrant got %b/%h/%b want 1/%h/00", t, mreq, madr, mwe, idx * 8); else pass_cnt++;
                wait_for(1, ok, cyc);
                instrreq = 1'b0;
                exp_i = (lane == 1) ? ref_mem[idx][63:32] : ref_mem[idx][31:0];
                total_cnt++; if (!ok || instr !== exp_i) $display("FAIL rnd%0d_instr got %h want %h", t, instr, exp_i); else pass_cnt++;
                $display("txn %0d fetch adr=%h instr=%h", t, instradr, instr);
            end else begin
                we = (kind == 0) ? 2'b00 : 2'($urandom_range(1, 3));
                wd = {$urandom, $urandom};
                dataadr = 64'(idx * 8); writedata = wd; memwrite = we;
                datareq = 1'b1;
                tick();
                total_cnt++; if ({mreq, madr, mwe, mwdata} !== {1'b1, 64'(idx * 8), we, wd}) $display("FAIL rnd%0d_dgrant got %b/%h/%b/%h want 1/%h/%b/%h", t, mreq, madr, mwe, mwdata, idx * 8, we, wd); else pass_cnt++;
                wait_for(2, ok, cyc);
                datareq = 1'b0;
                total_cnt++; if (!ok || readdata !== ref_mem[idx]) $display("FAIL rnd%0d_rdata got %h want %h", t, readdata, ref_mem[idx]); else pass_cnt++;
                if (we[0]) ref_mem[idx][31:0]  = wd[31:0];
                if (we[1]) ref_mem[idx][63:32] = wd[63:32];
                $display("txn %0d data adr=%h we=%b rdata=%h", t, dataadr, we, readdata);
            end
            tick();
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            mem[i]     = {$urandom, $urandom};
            ref_mem[i] = mem[i];
        end
        test_reset();
        test_reset_mid();
        test_fetch();
        test_load_store();
        test_starve();
        test_abort();
        test_hold();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one 64-bit backing memory port between the instruction-fetch side (instrreq/instradr/instr/hit/abort) and the data side (dataadr/writedata/memwrite/readdata) of the mips core.
- Serialises accesses and holds the memory request until the memory acknowledges it.
- Returns fetch data with a one-cycle hit pulse and data results with a one-cycle dataready pulse.
- Data has priority over fetch, and a starvation counter bounds how long a fetch can wait.

Parameters:
- N, 64, data/memory word width.
- STARVE, 4, consecutive data grants allowed while a fetch waits before the fetch is forced through. Range 1..15.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- instrreq  input  1  fetch request, held high until hit or abort.
- instradr  input  32  fetch byte address, word aligned.
- abort  input  1  core flush; kills a pending or in-flight fetch.
- instr  output  32  fetched instruction, valid while hit=1.
- hit  output  1  one-cycle fetch-complete pulse.
- datareq  input  1  data access request, held high until dataready.
- dataadr  input  N  data byte address, doubleword aligned.
- writedata  input  N  store data.
- memwrite  input  2  store enables: bit1 = upper 32 bits, bit0 = lower 32 bits; 00 = load.
- readdata  output  N  load result, valid while dataready=1.
- dataready  output  1  one-cycle data-complete pulse, for loads and stores.
- madr  output  N  memory address (doubleword aligned; bits [2:0] forced to 0).
- mwdata  output  N  memory write data.
- mwe  output  2  memory write enables.
- mreq  output  1  memory request.
- mrdata  input  N  memory read data, valid when mack=1.
- mack  input  1  memory acknowledge, one-cycle pulse.

Behaviour:
- States:
  - IDLE: no memory access in flight.
  - DBUSY: data access in flight.
  - IBUSY: fetch in flight.
- All outputs are registered.
- Reset, synchronous on clk: state=IDLE; mreq=0, mwe=00, madr=0, mwdata=0; hit=0, dataready=0, instr=0, readdata=0; starve counter=0; kill flag=0. A mack arriving after reset is ignored.
- IDLE grant rules:
  - datareq=1 and (instrreq=0, or abort=1, or starve<STARVE): grant data.
    - madr<=dataadr, mwdata<=writedata, mwe<=memwrite, mreq<=1, go DBUSY.
    - If instrreq=1 and abort=0, starve<=starve+1.
  - Otherwise, if instrreq=1 and abort=0: grant fetch.
    - madr<=instradr (bits [2:0] zeroed), mwe<=00, mreq<=1, starve<=0, go IBUSY.
  - Otherwise stay IDLE.
- Starve counter:
  - Saturates at STARVE.
  - Clears whenever a fetch is granted.
  - Clears whenever instrreq=0 in IDLE.
- DBUSY:
  - mreq, madr, mwe and mwdata are held stable until mack.
  - On mack: readdata<=mrdata (for loads and stores), dataready<=1 for one cycle, mreq<=0, mwe<=00, go IDLE.
- IBUSY:
  - abort=1 in any IBUSY cycle sets the kill flag.
  - On mack, not killed and abort=0: instr<=instradr[2] ? mrdata[63:32] : mrdata[31:0]; hit<=1 for one cycle.
  - On mack, killed or abort=1: result discarded, hit stays 0.
  - On mack, in all cases: mreq<=0, kill flag cleared, go IDLE.
- Latency:
  - Request sampled in IDLE at cycle t; mreq high from t+1.
  - mack at earliest t+1; completion pulse at t+2.
  - After completion the state returns to IDLE; the next grant occurs in the cycle after the pulse.
- Simultaneous requests: data wins unless starve==STARVE, in which case the fetch wins.
- Width: memory is N bits wide; the fetch uses instradr[2] to select the half-word (32-bit) lane. No partial-lane logic beyond mwe.
- A requester dropping its request mid-access is illegal, except fetch via abort. Behaviour for a dropped data request is undefined.
- No combinational path from any input to any output.

Test Plan:
- Reset mid-access: reset during DBUSY → next cycle mreq=0, dataready=0, state IDLE; a following mack produces no pulse.
- Fetch only: instrreq=1, instradr=0x0000_0004, mrdata=0x1111_2222_3333_4444, mack two cycles after mreq → madr=0, instr=0x1111_2222, hit pulses exactly one cycle.
- Load and store:
  - datareq=1, memwrite=00, dataadr=0x40 → madr=0x40, mwe=00, readdata=mrdata with one-cycle dataready.
  - Then memwrite=01, writedata=0xAAAA_BBBB_CCCC_DDDD → mwe=01, mwdata=0xAAAA_BBBB_CCCC_DDDD until mack.
- Simultaneous requests, STARVE=4: instrreq and datareq held high with back-to-back data requests → 4 data grants, then 1 fetch grant, then the counter resets to 0 and data is granted again.
- Abort: abort pulsed for one cycle during IBUSY; mack arrives 3 cycles later → hit never asserts; the next fetch request completes normally with hit=1.
- Hold stability: mack delayed 10 cycles → madr, mwe, mwdata and mreq unchanged every cycle until mack; exactly one completion pulse.
